// File: rtl/taxi_stat_accum_if.sv
// Statistics increment stream and host read port of taxi_stat_accum.
interface taxi_stat_accum_if #(
   parameter int unsigned INC_W = 16,
   parameter int unsigned ID_W  = 8,
   parameter int unsigned CNT_W = 64
);
   logic [INC_W-1:0] s_axis_stat_tdata;
   logic [ID_W-1:0]  s_axis_stat_tid;
   logic             s_axis_stat_tuser;
   logic             s_axis_stat_tvalid;
   logic             s_axis_stat_tready;
   logic             rd_req;
   logic [ID_W-1:0]  rd_addr;
   logic             rd_clear;
   logic             rd_ack;
   logic             rd_valid;
   logic [CNT_W-1:0] rd_data;

   // Stat source and host side
   modport master (
      output s_axis_stat_tdata, s_axis_stat_tid, s_axis_stat_tuser, s_axis_stat_tvalid,
      output rd_req, rd_addr, rd_clear,
      input  s_axis_stat_tready, rd_ack, rd_valid, rd_data
   );

   // Accumulator side
   modport slave (
      input  s_axis_stat_tdata, s_axis_stat_tid, s_axis_stat_tuser, s_axis_stat_tvalid,
      input  rd_req, rd_addr, rd_clear,
      output s_axis_stat_tready, rd_ack, rd_valid, rd_data
   );
endinterface

// File: rtl/taxi_stat_accum.sv
// Statistics accumulator: wide RAM-backed counters fed by a 16-bit increment
// stream, with a host read port that can atomically read-and-clear.
module taxi_stat_accum #(
   parameter int unsigned CNT   = 256,
   parameter int unsigned INC_W = 16,
   parameter int unsigned ID_W  = 8,
   parameter int unsigned CNT_W = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   taxi_stat_accum_if.slave stat_if,
   output logic             init_done
);
   localparam int unsigned AW    = (CNT > 1) ? $clog2(CNT) : 1;
   localparam int unsigned LIM_W = ID_W + 1;

   typedef enum logic {ST_INIT, ST_RUN} state_t;
   typedef enum logic [1:0] {OP_ADD, OP_LOAD, OP_READ} op_t;

   state_t          state_q, state_d;
   logic [AW-1:0]   init_cnt_q, init_cnt_d;
   logic            init_done_q, init_done_d;

   logic            tready_c, rd_ack_c, issue_vld_c, issue_oor_c;
   op_t             issue_op_c;
   logic [ID_W-1:0] issue_idx_c;

   logic             p1_vld_q, p1_oor_q, p1_clr_q;
   op_t              p1_op_q;
   logic [AW-1:0]    p1_idx_q;
   logic [INC_W-1:0] p1_opnd_q;
   logic [CNT_W-1:0] ram_rd_q;

   logic             wb_vld_q;
   logic [AW-1:0]    wb_idx_q;
   logic [CNT_W-1:0] wb_data_q;

   logic [CNT_W-1:0] cur_c, res_c;
   logic             wr_c;
   logic             mem_we_c;
   logic [AW-1:0]    mem_waddr_c;
   logic [CNT_W-1:0] mem_wdata_c;

   logic             rd_valid_q;
   logic [CNT_W-1:0] rd_data_q;

   logic [CNT_W-1:0] mem_q [CNT];

   // Init/run state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         init_cnt_q  <= '0;
         init_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         init_cnt_q  <= init_cnt_d;
         init_done_q <= init_done_d;
      end
   end

   // Sweep every counter to zero once, then run forever
   always_comb begin
      state_d     = state_q;
      init_cnt_d  = init_cnt_q;
      init_done_d = init_done_q;
      case (state_q)
         ST_INIT: begin
            init_cnt_d = init_cnt_q + AW'(1);
            if (init_cnt_q == AW'(CNT - 1)) begin
               state_d     = ST_RUN;
               init_cnt_d  = '0;
               init_done_d = 1'b1;
            end
         end
         ST_RUN:  ;
         default: state_d = ST_INIT;
      endcase
   end

   // Slot arbitration: a pending read always takes the issue slot
   always_comb begin
      tready_c    = init_done_q && !stat_if.rd_req;
      rd_ack_c    = init_done_q && stat_if.rd_req;
      issue_vld_c = rd_ack_c || (tready_c && stat_if.s_axis_stat_tvalid);
      issue_op_c  = stat_if.s_axis_stat_tuser ? OP_LOAD : OP_ADD;
      issue_idx_c = stat_if.s_axis_stat_tid;
      if (stat_if.rd_req) begin
         issue_op_c  = OP_READ;
         issue_idx_c = stat_if.rd_addr;
      end
      issue_oor_c = ({1'b0, issue_idx_c} >= LIM_W'(CNT));
   end

   // Compute stage; the previous op's write lands in the same edge as our RAM
   // read, so it is taken from the write-back register instead
   always_comb begin
      cur_c = (wb_vld_q && (wb_idx_q == p1_idx_q)) ? wb_data_q : ram_rd_q;
      res_c = '0;
      wr_c  = 1'b0;
      case (p1_op_q)
         OP_ADD:  begin res_c = cur_c + CNT_W'(p1_opnd_q); wr_c = 1'b1;     end
         OP_LOAD: begin res_c = CNT_W'(p1_opnd_q);         wr_c = 1'b1;     end
         OP_READ: begin res_c = '0;                        wr_c = p1_clr_q; end
         default: ;
      endcase
      if (!p1_vld_q || p1_oor_q) wr_c = 1'b0;
   end

   // RAM write port shared between the init sweep and write-back
   always_comb begin
      mem_we_c    = wr_c;
      mem_waddr_c = p1_idx_q;
      mem_wdata_c = res_c;
      if (state_q == ST_INIT) begin
         mem_we_c    = 1'b1;
         mem_waddr_c = init_cnt_q;
         mem_wdata_c = '0;
      end
   end

   // Counter RAM, read-before-write
   always_ff @(posedge clk) begin
      if (mem_we_c) mem_q[mem_waddr_c] <= mem_wdata_c;
      ram_rd_q <= mem_q[issue_idx_c[AW-1:0]];
   end

   // Pipeline registers, write-back forwarding copy and read result
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         p1_vld_q   <= 1'b0;
         p1_op_q    <= OP_ADD;
         p1_idx_q   <= '0;
         p1_oor_q   <= 1'b0;
         p1_clr_q   <= 1'b0;
         p1_opnd_q  <= '0;
         wb_vld_q   <= 1'b0;
         wb_idx_q   <= '0;
         wb_data_q  <= '0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         p1_vld_q   <= issue_vld_c;
         p1_op_q    <= issue_op_c;
         p1_idx_q   <= issue_idx_c[AW-1:0];
         p1_oor_q   <= issue_oor_c;
         p1_clr_q   <= stat_if.rd_clear;
         p1_opnd_q  <= stat_if.s_axis_stat_tdata;
         wb_vld_q   <= wr_c;
         wb_idx_q   <= p1_idx_q;
         wb_data_q  <= res_c;
         rd_valid_q <= p1_vld_q && (p1_op_q == OP_READ);
         if (p1_vld_q && (p1_op_q == OP_READ)) rd_data_q <= p1_oor_q ? '0 : cur_c;
      end
   end

   assign stat_if.s_axis_stat_tready = tready_c;
   assign stat_if.rd_ack             = rd_ack_c;
   assign stat_if.rd_valid           = rd_valid_q;
   assign stat_if.rd_data            = rd_data_q;
   assign init_done                  = init_done_q;
endmodule

// File: tb/tb_taxi_stat_accum.sv
// Scoreboard bench for taxi_stat_accum: a 256x64 instance and a 200x32 instance.
module tb_taxi_stat_accum;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic done0, done1;
   always #5 clk = ~clk;

   taxi_stat_accum_if #(.INC_W(16), .ID_W(8), .CNT_W(64)) sif0 ();
   taxi_stat_accum_if #(.INC_W(16), .ID_W(8), .CNT_W(32)) sif1 ();

   taxi_stat_accum #(.CNT(256), .INC_W(16), .ID_W(8), .CNT_W(64)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .stat_if(sif0), .init_done(done0));
   taxi_stat_accum #(.CNT(200), .INC_W(16), .ID_W(8), .CNT_W(32)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .stat_if(sif1), .init_done(done1));

   int          checks = 0;
   int          fails  = 0;
   int          stall0 = 0;
   int          rdv0   = 0;
   longint      cyc    = 0;
   logic [63:0] q0[$];
   string       nq0[$];
   logic [31:0] q1[$];
   string       nq1[$];
   longint      ackt0[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor for the 64-bit instance: value and ack-to-valid latency
   always @(negedge clk) begin
      if (sif0.rd_valid) begin
         rdv0++;
         if (q0.size() == 0) chk("dut0_unexpected_rd_valid", 64'd1, 64'd0);
         else chk(nq0.pop_front(), sif0.rd_data, q0.pop_front());
         if (ackt0.size() == 0) chk("dut0_valid_without_ack", 64'd1, 64'd0);
         else chk("dut0_ack_to_valid", 64'(cyc - ackt0.pop_front()), 64'd2);
      end
      if (!rst_n) ackt0.delete();
      else if (sif0.rd_ack) ackt0.push_back(cyc);
   end

   // Monitor for the 32-bit instance
   always @(negedge clk) begin
      if (sif1.rd_valid) begin
         if (q1.size() == 0) chk("dut1_unexpected_rd_valid", 64'd1, 64'd0);
         else chk(nq1.pop_front(), 64'(sif1.rd_data), 64'(q1.pop_front()));
      end
   end

   task automatic st0(input logic [7:0] id, input logic [15:0] d, input logic ld);
      int k = 0;
      sif0.s_axis_stat_tvalid = 1'b1;
      sif0.s_axis_stat_tid    = id;
      sif0.s_axis_stat_tdata  = d;
      sif0.s_axis_stat_tuser  = ld;
      @(negedge clk);
      while (!sif0.s_axis_stat_tready && k < 100) begin k++; stall0++; @(negedge clk); end
      if (!sif0.s_axis_stat_tready) chk("dut0_tready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      sif0.s_axis_stat_tvalid = 1'b0;
   endtask

   task automatic st1(input logic [7:0] id, input logic [15:0] d, input logic ld);
      int k = 0;
      sif1.s_axis_stat_tvalid = 1'b1;
      sif1.s_axis_stat_tid    = id;
      sif1.s_axis_stat_tdata  = d;
      sif1.s_axis_stat_tuser  = ld;
      @(negedge clk);
      while (!sif1.s_axis_stat_tready && k < 100) begin k++; @(negedge clk); end
      if (!sif1.s_axis_stat_tready) chk("dut1_tready_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      sif1.s_axis_stat_tvalid = 1'b0;
   endtask

   task automatic rd0(input logic [7:0] a, input logic clr, input logic [63:0] e,
                      input bit push, input string nm);
      int k = 0;
      if (push) begin q0.push_back(e); nq0.push_back(nm); end
      sif0.rd_req = 1'b1; sif0.rd_addr = a; sif0.rd_clear = clr;
      @(negedge clk);
      while (!sif0.rd_ack && k < 100) begin k++; @(negedge clk); end
      if (!sif0.rd_ack) chk("dut0_rd_ack_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      sif0.rd_req = 1'b0; sif0.rd_clear = 1'b0;
   endtask

   task automatic rd1(input logic [7:0] a, input logic clr, input logic [31:0] e, input string nm);
      int k = 0;
      q1.push_back(e); nq1.push_back(nm);
      sif1.rd_req = 1'b1; sif1.rd_addr = a; sif1.rd_clear = clr;
      @(negedge clk);
      while (!sif1.rd_ack && k < 100) begin k++; @(negedge clk); end
      if (!sif1.rd_ack) chk("dut1_rd_ack_timeout", 64'd0, 64'd1);
      @(posedge clk); #1;
      sif1.rd_req = 1'b0; sif1.rd_clear = 1'b0;
   endtask

   // Counts edges from reset release to init_done on both instances
   task automatic wait_init();
      int n0 = 0, n1 = 0, bad = 0;
      for (int k = 1; k <= 600; k++) begin
         @(posedge clk); #1;
         if (!done0 && sif0.s_axis_stat_tready) bad++;
         if (!done1 && sif1.s_axis_stat_tready) bad++;
         if (done0 && n0 == 0) n0 = k;
         if (done1 && n1 == 0) n1 = k;
         if (n0 != 0 && n1 != 0) break;
      end
      chk("init_cycles_dut0", 64'(n0), 64'd256);
      chk("init_cycles_dut1", 64'(n1), 64'd200);
      chk("tready_before_init_done", 64'(bad), 64'd0);
   endtask

   task automatic read_all_zero(input string tag);
      fork
         for (int i = 0; i < 256; i++) rd0(8'(i), 1'b0, 64'd0, 1'b1, $sformatf("%s_dut0_idx%0d", tag, i));
         for (int i = 0; i < 200; i++) rd1(8'(i), 1'b0, 32'd0, $sformatf("%s_dut1_idx%0d", tag, i));
      join
   endtask

   initial begin
      #1_500_000;
      fails++;
      $display("FAIL watchdog_timeout actual=running expected=finished");
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      sif0.s_axis_stat_tvalid = 1'b0; sif0.s_axis_stat_tid = '0; sif0.s_axis_stat_tdata = '0;
      sif0.s_axis_stat_tuser = 1'b0; sif0.rd_req = 1'b0; sif0.rd_addr = '0; sif0.rd_clear = 1'b0;
      sif1.s_axis_stat_tvalid = 1'b0; sif1.s_axis_stat_tid = '0; sif1.s_axis_stat_tdata = '0;
      sif1.s_axis_stat_tuser = 1'b0; sif1.rd_req = 1'b0; sif1.rd_addr = '0; sif1.rd_clear = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_init_done0", 64'(done0), 64'd0);
      chk("rst_init_done1", 64'(done1), 64'd0);
      chk("rst_tready0", 64'(sif0.s_axis_stat_tready), 64'd0);
      chk("rst_rd_ack0", 64'(sif0.rd_ack), 64'd0);
      chk("rst_rd_valid0", 64'(sif0.rd_valid), 64'd0);
      chk("rst_rd_data0", sif0.rd_data, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_init();
      read_all_zero("postinit");

      // Back-to-back accumulate on one index
      stall0 = 0;
      for (int i = 0; i < 1000; i++) st0(8'd7, 16'hFFFF, 1'b0);
      chk("b2b_tready_stalls", 64'(stall0), 64'd0);
      rd0(8'd7, 1'b0, 64'h0000_0000_03E7_FC18, 1'b1, "b2b_sum_idx7");

      // Same-index hazards on consecutive cycles
      st0(8'd2, 16'd3, 1'b0);
      rd0(8'd2, 1'b1, 64'd3, 1'b1, "haz_rdclr_idx2");
      st0(8'd2, 16'd5, 1'b0);
      rd0(8'd2, 1'b0, 64'd5, 1'b1, "haz_rd_idx2");
      st0(8'd9, 16'd100, 1'b0);
      st0(8'd9, 16'h1234, 1'b1);
      st0(8'd9, 16'd1, 1'b0);
      rd0(8'd9, 1'b0, 64'h1235, 1'b1, "haz_load_add_idx9");
      st0(8'd30, 16'd4, 1'b0);
      st0(8'd31, 16'd6, 1'b0);
      rd0(8'd30, 1'b0, 64'd4, 1'b1, "gap_idx30");
      rd0(8'd31, 1'b0, 64'd6, 1'b1, "gap_idx31");
      rd0(8'd2, 1'b0, 64'd5, 1'b1, "haz_rd_again_idx2");

      // Read and record contend for the same slot
      q0.push_back(64'd0); nq0.push_back("arb_read_first_idx20");
      sif0.s_axis_stat_tvalid = 1'b1; sif0.s_axis_stat_tid = 8'd20;
      sif0.s_axis_stat_tdata = 16'd10; sif0.s_axis_stat_tuser = 1'b0;
      sif0.rd_req = 1'b1; sif0.rd_addr = 8'd20; sif0.rd_clear = 1'b0;
      @(negedge clk);
      chk("arb_tready_low", 64'(sif0.s_axis_stat_tready), 64'd0);
      chk("arb_rd_ack", 64'(sif0.rd_ack), 64'd1);
      @(posedge clk); #1;
      sif0.rd_req = 1'b0;
      @(negedge clk);
      chk("arb_tready_back", 64'(sif0.s_axis_stat_tready), 64'd1);
      @(posedge clk); #1;
      sif0.s_axis_stat_tvalid = 1'b0;
      rd0(8'd20, 1'b0, 64'd10, 1'b1, "arb_record_kept_idx20");

      // Long sums and 32-bit wrap in parallel
      fork
         begin
            st0(8'd1, 16'hFFFF, 1'b1);
            for (int i = 0; i < 65536; i++) st0(8'd1, 16'hFFFF, 1'b0);
            rd0(8'd1, 1'b0, 64'h0000_0000_FFFF_FFFF, 1'b1, "wide_sum_idx1");
         end
         begin
            st1(8'd5, 16'hFFFF, 1'b1);
            st1(8'd5, 16'd1, 1'b0);
            rd1(8'd5, 1'b0, 32'h0001_0000, "w32_load_add1");
            st1(8'd6, 16'hFFFF, 1'b1);
            for (int i = 0; i < 65536; i++) st1(8'd6, 16'hFFFF, 1'b0);
            rd1(8'd6, 1'b0, 32'hFFFF_FFFF, "w32_full");
            st1(8'd6, 16'hFFFF, 1'b0);
            rd1(8'd6, 1'b0, 32'h0000_FFFE, "w32_wrap");
            st1(8'hFF, 16'd7, 1'b0);
            st1(8'd200, 16'd9, 1'b1);
            st1(8'd199, 16'd9, 1'b0);
            rd1(8'hFF, 1'b0, 32'd0, "oor_rd_255");
            rd1(8'd200, 1'b0, 32'd0, "oor_rd_200");
            rd1(8'd199, 1'b0, 32'd9, "last_idx199");
            rd1(8'hFF, 1'b1, 32'd0, "oor_rdclr_255");
            rd1(8'd0, 1'b0, 32'd0, "idx0_untouched");
         end
      join

      // Reset while a read sits in the pipeline
      rd0(8'd7, 1'b0, 64'd0, 1'b0, "discarded");
      rst_n = 1'b0;
      base  = rdv0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_init();
      chk("rst_discards_read", 64'(rdv0 - base), 64'd0);
      read_all_zero("rerun");

      for (int k = 0; k < 20 && (q0.size() != 0 || q1.size() != 0); k++) @(posedge clk);
      chk("sb_drained_dut0", 64'(q0.size()), 64'd0);
      chk("sb_drained_dut1", 64'(q1.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end
endmodule
